// File: rtl/digital_clock_ctrl.sv
// Wishbone-slave sequencer for the digital-clock datapath: prescaled tick, validated time load,
// alarm compare/IRQ and pad OEB. Optional single-step trigger via macro DCLK_CTRL_STEP_EN.
module digital_clock_ctrl #(
  parameter logic [31:0]         BASE_ADDR = 32'h3000_0000,
  parameter int unsigned         PRESC_W   = 26,
  parameter logic [PRESC_W-1:0]  PRESC_RST = PRESC_W'(9_999_999)
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  input  logic [5:0]  cur_hours,
  input  logic [5:0]  cur_minutes,
  input  logic [5:0]  cur_seconds,
  output logic        tick_o,
  output logic        time_load_o,
  output logic [5:0]  load_hours_o,
  output logic [5:0]  load_minutes_o,
  output logic [5:0]  load_seconds_o,
  output logic [17:0] time_oeb_o,
  output logic        irq_o
);

  localparam int unsigned FLD_W = 6;
  localparam int unsigned HR_W  = 5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_LOAD   = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

  localparam logic [2:0] R_CTRL   = 3'd0;
  localparam logic [2:0] R_PRESC  = 3'd1;
  localparam logic [2:0] R_SET    = 3'd2;
  localparam logic [2:0] R_ALARM  = 3'd3;
  localparam logic [2:0] R_STATUS = 3'd4;
  localparam logic [2:0] R_TIME   = 3'd5;

  logic [1:0]         state_q, state_d;
  logic               run_q, run_d;
  logic               out_en_q, out_en_d;
  logic               alarm_en_q, alarm_en_d;
  logic [PRESC_W-1:0] prescale_q, prescale_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [FLD_W-1:0]   set_sec_q, set_sec_d, set_min_q, set_min_d;
  logic [HR_W-1:0]    set_hr_q, set_hr_d;
  logic [FLD_W-1:0]   al_sec_q, al_sec_d, al_min_q, al_min_d;
  logic [HR_W-1:0]    al_hr_q, al_hr_d;
  logic [FLD_W-1:0]   cap_sec_q, cap_sec_d, cap_min_q, cap_min_d;
  logic [HR_W-1:0]    cap_hr_q, cap_hr_d;
  logic               flag_q, flag_d;
  logic               err_q, err_d;
  logic               match_q, match_d;
  logic               irq_q, irq_d;
  logic               tick_q, tick_d;
  logic               tl_q, tl_d;
  logic [FLD_W-1:0]   ld_h_q, ld_h_d, ld_m_q, ld_m_d, ld_s_q, ld_s_d;
  logic [17:0]        oeb_q, oeb_d;
  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;
`ifdef DCLK_CTRL_STEP_EN
  logic               step_q, step_d;
`endif

  logic        acc_c, wr_c, rd_c;
  logic [2:0]  reg_sel_c;
  logic [31:0] rd_view_c, wmerge_c, bmask_c;
  logic        load_trig_c, clr_flag_c, clr_err_c, presc_wr_c, err_set_c, match_c, advance_c;
  logic        unused_c;

  assign acc_c     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
  assign wr_c      = acc_c & wbs_we_i;
  assign rd_c      = acc_c & ~wbs_we_i;
  assign reg_sel_c = wbs_adr_i[4:2];
  assign bmask_c   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wmerge_c  = (rd_view_c & ~bmask_c) | (wbs_dat_i & bmask_c);
  assign unused_c  = ^{wbs_adr_i[7:5], wbs_adr_i[1:0], wmerge_c};

  assign match_c = alarm_en_q & (cur_hours == {1'b0, al_hr_q}) &
                   (cur_minutes == al_min_q) & (cur_seconds == al_sec_q);

  // Register view shared by read data and byte-masked write merge
  always_comb begin
    rd_view_c = 32'd0;
    case (reg_sel_c)
      R_CTRL:   rd_view_c = {29'd0, alarm_en_q, out_en_q, run_q};
      R_PRESC:  rd_view_c = 32'(prescale_q);
      R_SET:    rd_view_c = {11'd0, set_hr_q, 2'd0, set_min_q, 2'd0, set_sec_q};
      R_ALARM:  rd_view_c = {11'd0, al_hr_q, 2'd0, al_min_q, 2'd0, al_sec_q};
      R_STATUS: rd_view_c = {29'd0, err_q, (state_q != ST_IDLE), flag_q};
      R_TIME:   rd_view_c = {10'd0, cur_hours, 2'd0, cur_minutes, 2'd0, cur_seconds};
      default:  rd_view_c = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    out_en_d   = out_en_q;
    alarm_en_d = alarm_en_q;
    prescale_d = prescale_q;
    cnt_d      = cnt_q;
    set_sec_d  = set_sec_q;
    set_min_d  = set_min_q;
    set_hr_d   = set_hr_q;
    al_sec_d   = al_sec_q;
    al_min_d   = al_min_q;
    al_hr_d    = al_hr_q;
    cap_sec_d  = cap_sec_q;
    cap_min_d  = cap_min_q;
    cap_hr_d   = cap_hr_q;
    ld_h_d     = ld_h_q;
    ld_m_d     = ld_m_q;
    ld_s_d     = ld_s_q;
    tick_d     = 1'b0;
    tl_d       = 1'b0;
    ack_d      = acc_c;
    dat_d      = 32'd0;
    load_trig_c = 1'b0;
    clr_flag_c  = 1'b0;
    clr_err_c   = 1'b0;
    presc_wr_c  = 1'b0;
    err_set_c   = 1'b0;
    advance_c   = 1'b0;
`ifdef DCLK_CTRL_STEP_EN
    step_d      = 1'b0;
`endif

    if (wr_c) begin
      case (reg_sel_c)
        R_CTRL: begin
          run_d       = wmerge_c[0];
          out_en_d    = wmerge_c[1];
          alarm_en_d  = wmerge_c[2];
          load_trig_c = wbs_sel_i[0] & wbs_dat_i[3];
`ifdef DCLK_CTRL_STEP_EN
          step_d      = wbs_sel_i[0] & wbs_dat_i[4] & ~wmerge_c[0] &
                        (state_q == ST_IDLE) & ~load_trig_c;
`endif
        end
        R_PRESC: begin
          prescale_d = wmerge_c[PRESC_W-1:0];
          presc_wr_c = 1'b1;
        end
        R_SET: begin
          set_sec_d = wmerge_c[5:0];
          set_min_d = wmerge_c[13:8];
          set_hr_d  = wmerge_c[20:16];
        end
        R_ALARM: begin
          al_sec_d = wmerge_c[5:0];
          al_min_d = wmerge_c[13:8];
          al_hr_d  = wmerge_c[20:16];
        end
        R_STATUS: begin
          clr_flag_c = wbs_sel_i[0] & wbs_dat_i[0];
          clr_err_c  = wbs_sel_i[0] & wbs_dat_i[2];
        end
        default: ;
      endcase
    end

    if (rd_c) dat_d = rd_view_c;

    // Load sequencer; a LOAD trigger while busy is simply dropped
    case (state_q)
      ST_IDLE: begin
        if (load_trig_c) begin
          state_d   = ST_CHECK;
          cap_sec_d = set_sec_q;
          cap_min_d = set_min_q;
          cap_hr_d  = set_hr_q;
        end
      end
      ST_CHECK: begin
        if ((cap_sec_q > 6'd59) || (cap_min_q > 6'd59) || (cap_hr_q > 5'd23)) begin
          err_set_c = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_LOAD;
          tl_d    = 1'b1;
          ld_h_d  = {1'b0, cap_hr_q};
          ld_m_d  = cap_min_q;
          ld_s_d  = cap_sec_q;
        end
      end
      ST_LOAD:   state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Prescaler only advances while idle now and next cycle, so no tick lands in a busy state
    advance_c = run_q & (state_q == ST_IDLE) & (state_d == ST_IDLE);
    if (presc_wr_c || (state_q == ST_SETTLE)) begin
      cnt_d = '0;
    end else if (advance_c) begin
      if (cnt_q == prescale_q) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + PRESC_W'(1);
      end
    end
`ifdef DCLK_CTRL_STEP_EN
    if (step_q && (state_q == ST_IDLE)) tick_d = 1'b1;
`endif

    match_d = match_c;
    flag_d  = (match_c & ~match_q) | (flag_q & ~clr_flag_c);
    err_d   = err_set_c | (err_q & ~clr_err_c);
    irq_d   = flag_q;
    oeb_d   = {18{~out_en_q}};
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      run_q      <= 1'b0;
      out_en_q   <= 1'b0;
      alarm_en_q <= 1'b0;
      prescale_q <= PRESC_RST;
      cnt_q      <= '0;
      set_sec_q  <= '0;
      set_min_q  <= '0;
      set_hr_q   <= '0;
      al_sec_q   <= '0;
      al_min_q   <= '0;
      al_hr_q    <= '0;
      cap_sec_q  <= '0;
      cap_min_q  <= '0;
      cap_hr_q   <= '0;
      flag_q     <= 1'b0;
      err_q      <= 1'b0;
      match_q    <= 1'b0;
      irq_q      <= 1'b0;
      tick_q     <= 1'b0;
      tl_q       <= 1'b0;
      ld_h_q     <= '0;
      ld_m_q     <= '0;
      ld_s_q     <= '0;
      oeb_q      <= 18'h3FFFF;
      ack_q      <= 1'b0;
      dat_q      <= 32'd0;
`ifdef DCLK_CTRL_STEP_EN
      step_q     <= 1'b0;
`endif
    end else begin
      run_q      <= run_d;
      out_en_q   <= out_en_d;
      alarm_en_q <= alarm_en_d;
      prescale_q <= prescale_d;
      cnt_q      <= cnt_d;
      set_sec_q  <= set_sec_d;
      set_min_q  <= set_min_d;
      set_hr_q   <= set_hr_d;
      al_sec_q   <= al_sec_d;
      al_min_q   <= al_min_d;
      al_hr_q    <= al_hr_d;
      cap_sec_q  <= cap_sec_d;
      cap_min_q  <= cap_min_d;
      cap_hr_q   <= cap_hr_d;
      flag_q     <= flag_d;
      err_q      <= err_d;
      match_q    <= match_d;
      irq_q      <= irq_d;
      tick_q     <= tick_d;
      tl_q       <= tl_d;
      ld_h_q     <= ld_h_d;
      ld_m_q     <= ld_m_d;
      ld_s_q     <= ld_s_d;
      oeb_q      <= oeb_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
`ifdef DCLK_CTRL_STEP_EN
      step_q     <= step_d;
`endif
    end
  end

  assign wbs_ack_o      = ack_q;
  assign wbs_dat_o      = dat_q;
  assign tick_o         = tick_q;
  assign time_load_o    = tl_q;
  assign load_hours_o   = ld_h_q;
  assign load_minutes_o = ld_m_q;
  assign load_seconds_o = ld_s_q;
  assign time_oeb_o     = oeb_q;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_digital_clock_ctrl.sv
// Directed self-checking bench for digital_clock_ctrl (default build).
module tb_digital_clock_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic [31:0] rdat;
  logic        ack;
  logic [5:0]  cur_h, cur_m, cur_s;
  logic        tick, tl;
  logic [5:0]  ld_h, ld_m, ld_s;
  logic [17:0] oeb;
  logic        irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  digital_clock_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(rdat), .wbs_ack_o(ack),
    .cur_hours(cur_h), .cur_minutes(cur_m), .cur_seconds(cur_s),
    .tick_o(tick), .time_load_o(tl),
    .load_hours_o(ld_h), .load_minutes_o(ld_m), .load_seconds_o(ld_s),
    .time_oeb_o(oeb), .irq_o(irq)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit got = 1'b0;
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      got = ack;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    total++;
    if (!got) begin bad++; $display("FAIL wr_ack adr=%h: got no ack, want ack", a); end
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    bit got = 1'b0;
    d = 32'hDEAD_BEEF;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      got = ack;
      if (got) d = rdat;
    end
    stb = 1'b0; cyc = 1'b0;
    total++;
    if (!got) begin bad++; $display("FAIL rd_ack adr=%h: got no ack, want ack", a); end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) step();
    total++; if (oeb !== 18'h3FFFF) begin bad++; $display("FAIL rst_oeb got=%h want=3ffff", oeb); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b want=0", irq); end
    total++; if (tick !== 1'b0 || tl !== 1'b0) begin bad++; $display("FAIL rst_strobes tick=%b tl=%b want 0/0", tick, tl); end
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h4;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL rst_noack cyc%0d got=%b want=0", i, ack); end
    end
    stb = 1'b0; cyc = 1'b0;
    rst = 1'b0;
    step();
    wb_read(BASE + 32'h4, d);
    total++; if (d !== 32'h0098_967F) begin bad++; $display("FAIL rst_presc got=%h want=0098967f", d); end
    wb_read(BASE + 32'h0, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_ctrl got=%h want=0", d); end
  endtask

  task automatic test_tick();
    int n;
    bit found;
    wb_write(BASE + 32'h4, 32'd4, 4'hF);
    wb_write(BASE + 32'h0, 32'h3, 4'hF);
    repeat (2) step();
    total++; if (oeb !== 18'h0) begin bad++; $display("FAIL tick_oeb got=%h want=0", oeb); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin step(); found = tick; end
    total++; if (!found) begin bad++; $display("FAIL tick_first got=none want=pulse in 20 cycles"); end
    for (int k = 0; k < 2; k++) begin
      n = 0;
      for (int i = 0; i < 20; i++) begin
        step();
        n++;
        if (tick) break;
      end
      total++; if (n != 5) begin bad++; $display("FAIL tick_period%0d got=%0d want=5", k, n); end
    end
    wb_write(BASE + 32'h0, 32'h2, 4'hF);
    n = 0;
    for (int i = 0; i < 15; i++) begin step(); if (tick) n++; end
    total++; if (n != 0) begin bad++; $display("FAIL tick_stop got=%0d ticks want=0", n); end
  endtask

  task automatic test_load();
    logic [31:0] d;
    int tl_cnt;
    wb_write(BASE + 32'h8, 32'h000C_2238, 4'hF);
    wb_write(BASE + 32'h0, 32'hB, 4'hF);
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL load_tick0 got=%b want=0", tick); end
    tl_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (tl) tl_cnt++;
      if (i == 1) begin
        total++;
        if (tl !== 1'b1 || ld_h !== 6'd12 || ld_m !== 6'd34 || ld_s !== 6'd56) begin
          bad++; $display("FAIL load_strobe tl=%b h=%0d m=%0d s=%0d want 1/12/34/56", tl, ld_h, ld_m, ld_s);
        end
      end
      total++;
      if (tick !== (i == 8)) begin bad++; $display("FAIL load_tick cyc%0d got=%b want=%b", i, tick, (i == 8)); end
    end
    total++; if (tl_cnt != 1) begin bad++; $display("FAIL load_once got=%0d want=1", tl_cnt); end
    // Second load with run off: poll busy during the sequence and right after it
    wb_write(BASE + 32'h0, 32'hA, 4'hF);
    wb_read(BASE + 32'h10, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL load_busy got=%h want=2", d); end
    wb_read(BASE + 32'h10, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL load_idle got=%h want=0", d); end
  endtask

  task automatic test_load_err();
    logic [31:0] d;
    int tl_cnt = 0;
    wb_write(BASE + 32'h8, 32'h000C_223C, 4'hF);
    wb_write(BASE + 32'h0, 32'hA, 4'hF);
    for (int i = 0; i < 6; i++) begin step(); if (tl) tl_cnt++; end
    total++; if (tl_cnt != 0) begin bad++; $display("FAIL err_nostrobe got=%0d want=0", tl_cnt); end
    wb_read(BASE + 32'h10, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL err_flag got=%h want=4", d); end
    wb_write(BASE + 32'h10, 32'h4, 4'hF);
    wb_read(BASE + 32'h10, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL err_w1c got=%h want=0", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    bit got = 1'b0;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3000_0100; sel = 4'hF;
    for (int i = 0; i < 6; i++) begin step(); if (ack) got = 1'b1; end
    stb = 1'b0; cyc = 1'b0;
    total++; if (got) begin bad++; $display("FAIL win_miss got=ack want=no ack"); end
    wb_read(BASE + 32'h1C, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL off1c got=%h want=0", d); end
    step();
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL ack_width got=%b want=0", ack); end
    wb_read(BASE + 32'h14, d);
    total++; if (d !== 32'h0000_0004) begin bad++; $display("FAIL time_rd got=%h want=00000004", d); end
    wb_write(BASE + 32'h8, 32'h0017_3B07, 4'b0001);
    wb_read(BASE + 32'h8, d);
    total++; if (d !== 32'h000C_2207) begin bad++; $display("FAIL bytesel got=%h want=000c2207", d); end
  endtask

  task automatic test_alarm();
    logic [31:0] d;
    wb_write(BASE + 32'hC, 32'h0000_0005, 4'hF);
    wb_write(BASE + 32'h0, 32'h7, 4'hF);
    repeat (2) step();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL alm_idle got=%b want=0", irq); end
    cur_s = 6'd5;
    step();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL alm_latency got=%b want=0", irq); end
    step();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL alm_irq got=%b want=1", irq); end
    repeat (4) step();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL alm_hold got=%b want=1", irq); end
    wb_read(BASE + 32'h10, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL alm_status got=%h want=1", d); end
    cur_s = 6'd6;
    repeat (2) step();
    cur_s = 6'd5;
    wb_write(BASE + 32'h10, 32'h1, 4'hF);
    repeat (2) step();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL alm_setwins got=%b want=1", irq); end
    wb_write(BASE + 32'h0, 32'h3, 4'hF);
    repeat (2) step();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL alm_en_off got=%b want=1", irq); end
    wb_write(BASE + 32'h10, 32'h1, 4'hF);
    repeat (2) step();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL alm_clear got=%b want=0", irq); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wb_write(BASE + 32'h8, 32'h0001_0203, 4'hF);
    wb_write(BASE + 32'h0, 32'hB, 4'hF);
    rst = 1'b1;
    step();
    total++; if (tl !== 1'b0 || ack !== 1'b0) begin bad++; $display("FAIL mid_abort tl=%b ack=%b want 0/0", tl, ack); end
    total++; if (oeb !== 18'h3FFFF) begin bad++; $display("FAIL mid_oeb got=%h want=3ffff", oeb); end
    rst = 1'b0;
    step();
    wb_read(BASE + 32'h0, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_ctrl got=%h want=0", d); end
    wb_read(BASE + 32'h8, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_set got=%h want=0", d); end
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
    cur_h = 6'd0; cur_m = 6'd0; cur_s = 6'd4;
    test_reset();
    test_tick();
    test_load();
    test_load_err();
    test_regs();
    test_alarm();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
